// File: rtl/sha256_compress.sv
// sha256_compress: SHA-256 round engine folding one 512-bit block per START into H0..H7.
// Optional SHA224_MODE_EN adds SEL224 to select the SHA-224 IV and zero DIGEST[31:0].
module sha256_compress (
  input  logic         CLK,
  input  logic         RST,
  input  logic         INIT,
  input  logic         START,
`ifdef SHA224_MODE_EN
  input  logic         SEL224,
`endif
  input  logic [31:0]  W_IN,
  input  logic         W_VLD,
  output logic [5:0]   I,
  output logic         BUSY,
  output logic         DONE,
  output logic [255:0] DIGEST
);
  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_t;
  state_t state;
  logic [31:0] a, b, c, d, e, f, g, h, s0, s1, ch, maj, t1, t2;
  logic [255:0] hv, iv;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] k_rom(input logic [5:0] n);
    case (n)
      6'd0:  return 32'h428a2f98; 6'd1:  return 32'h71374491; 6'd2:  return 32'hb5c0fbcf; 6'd3:  return 32'he9b5dba5;
      6'd4:  return 32'h3956c25b; 6'd5:  return 32'h59f111f1; 6'd6:  return 32'h923f82a4; 6'd7:  return 32'hab1c5ed5;
      6'd8:  return 32'hd807aa98; 6'd9:  return 32'h12835b01; 6'd10: return 32'h243185be; 6'd11: return 32'h550c7dc3;
      6'd12: return 32'h72be5d74; 6'd13: return 32'h80deb1fe; 6'd14: return 32'h9bdc06a7; 6'd15: return 32'hc19bf174;
      6'd16: return 32'he49b69c1; 6'd17: return 32'hefbe4786; 6'd18: return 32'h0fc19dc6; 6'd19: return 32'h240ca1cc;
      6'd20: return 32'h2de92c6f; 6'd21: return 32'h4a7484aa; 6'd22: return 32'h5cb0a9dc; 6'd23: return 32'h76f988da;
      6'd24: return 32'h983e5152; 6'd25: return 32'ha831c66d; 6'd26: return 32'hb00327c8; 6'd27: return 32'hbf597fc7;
      6'd28: return 32'hc6e00bf3; 6'd29: return 32'hd5a79147; 6'd30: return 32'h06ca6351; 6'd31: return 32'h14292967;
      6'd32: return 32'h27b70a85; 6'd33: return 32'h2e1b2138; 6'd34: return 32'h4d2c6dfc; 6'd35: return 32'h53380d13;
      6'd36: return 32'h650a7354; 6'd37: return 32'h766a0abb; 6'd38: return 32'h81c2c92e; 6'd39: return 32'h92722c85;
      6'd40: return 32'ha2bfe8a1; 6'd41: return 32'ha81a664b; 6'd42: return 32'hc24b8b70; 6'd43: return 32'hc76c51a3;
      6'd44: return 32'hd192e819; 6'd45: return 32'hd6990624; 6'd46: return 32'hf40e3585; 6'd47: return 32'h106aa070;
      6'd48: return 32'h19a4c116; 6'd49: return 32'h1e376c08; 6'd50: return 32'h2748774c; 6'd51: return 32'h34b0bcb5;
      6'd52: return 32'h391c0cb3; 6'd53: return 32'h4ed8aa4a; 6'd54: return 32'h5b9cca4f; 6'd55: return 32'h682e6ff3;
      6'd56: return 32'h748f82ee; 6'd57: return 32'h78a5636f; 6'd58: return 32'h84c87814; 6'd59: return 32'h8cc70208;
      6'd60: return 32'h90befffa; 6'd61: return 32'ha4506ceb; 6'd62: return 32'hbef9a3f7;
      default: return 32'hc67178f2;
    endcase
  endfunction
`ifdef SHA224_MODE_EN
  localparam logic [255:0] IV224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  logic m224;
  assign iv = SEL224 ? IV224 : IV256;
  assign DIGEST = {hv[255:32], m224 ? 32'h0 : hv[31:0]};
  // The truncation mode follows SEL224 at reset and at every honoured INIT.
  always_ff @(posedge CLK)
    if (RST || (state == IDLE && INIT)) m224 <= SEL224;
`else
  assign iv = IV256;
  assign DIGEST = hv;
`endif
  always_comb begin
    s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    ch = (e & f) ^ (~e & g);
    t1 = h + s1 + ch + k_rom(I) + W_IN;
    s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t2 = s0 + maj;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      hv <= IV256;
      {a, b, c, d, e, f, g, h} <= '0;
      I <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (INIT) hv <= iv;
          if (START) begin
            {a, b, c, d, e, f, g, h} <= INIT ? iv : hv;
            I <= '0;
            BUSY <= 1'b1;
            state <= ROUND;
          end
        end
        ROUND: if (W_VLD) begin
          {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
          I <= I + 6'd1;
          if (I == 6'd63) state <= UPDATE;
        end
        UPDATE: begin
          hv <= {hv[255:224] + a, hv[223:192] + b, hv[191:160] + c, hv[159:128] + d,
                 hv[127:96] + e, hv[95:64] + f, hv[63:32] + g, hv[31:0] + h};
          DONE <= 1'b1;
          BUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: directed FIPS 180-4 vectors for sha256_compress; the bench plays the
// message-schedule stage, answering each requested index I with W[I].
module tb_sha256_compress;
  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  logic CLK = 1'b0, RST = 1'b1, INIT = 1'b0, START = 1'b0, W_VLD = 1'b0;
  logic [31:0] W_IN;
  logic [5:0] I;
  logic BUSY, DONE;
  logic [255:0] DIGEST;
`ifdef SHA224_MODE_EN
  logic SEL224 = 1'b0;
`endif
  logic [31:0] msg [16];
  logic [31:0] sched [64];
  int total = 0, bad = 0, lat;
  logic done_seen;

  sha256_compress dut (
    .CLK(CLK), .RST(RST), .INIT(INIT), .START(START),
`ifdef SHA224_MODE_EN
    .SEL224(SEL224),
`endif
    .W_IN(W_IN), .W_VLD(W_VLD), .I(I), .BUSY(BUSY), .DONE(DONE), .DIGEST(DIGEST)
  );

  assign W_IN = sched[I];
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic prep();
    for (int t = 0; t < 64; t++)
      if (t < 16) sched[t] = msg[t];
      else sched[t] = (rotr(sched[t-2], 17) ^ rotr(sched[t-2], 19) ^ (sched[t-2] >> 10)) + sched[t-7]
                    + (rotr(sched[t-15], 7) ^ rotr(sched[t-15], 18) ^ (sched[t-15] >> 3)) + sched[t-16];
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One block: optional INIT with START, optional 1,0,1,0 W_VLD stalls, optional
  // START+INIT glitch at a given cycle; returns edges from START to the DONE cycle.
  task automatic run_block(input bit with_init, input bit stall, input int glitch_at, output int n);
    logic [255:0] held;
    prep();
    @(negedge CLK); INIT = with_init; START = 1'b1; W_VLD = 1'b1;
    @(negedge CLK); INIT = 1'b0; START = 1'b0;
    held = DIGEST;
    n = 0;
    while (n < 400) begin
      @(negedge CLK);
      n++;
      if (DONE) break;
      if (n == 10) begin
        chk("busy_mid", BUSY, 1);
        chk("i_mid", I, stall ? 5 : 10);
        chk("digest_hold", DIGEST, held);
      end
      W_VLD = stall ? ~W_VLD : 1'b1;
      START = (n == glitch_at);
      INIT = (n == glitch_at);
    end
    W_VLD = 1'b0; START = 1'b0; INIT = 1'b0;
    chk("done_pulse", DONE, 1);
    @(negedge CLK);
    chk("done_clear", DONE, 0);
    chk("idle_busy", BUSY, 0);
    chk("idle_i", I, 0);
  endtask

  initial begin
    msg = '{default: 32'h0};
    prep();
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_i", I, 0);
    chk("rst_digest", DIGEST, IV256);

    msg = '{default: 32'h0}; msg[0] = 32'h61626380; msg[15] = 32'h18;
    run_block(1'b1, 1'b0, -1, lat);
    chk("abc_latency", lat, 65);
    chk("abc_digest", DIGEST, ABC);

    // Reset at round 30 of a block chained onto the abc digest.
    prep();
    @(negedge CLK); START = 1'b1; W_VLD = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (30) @(negedge CLK);
    chk("mid_i", I, 30);
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_digest", DIGEST, IV256);
    chk("mid_rst_i", I, 0);
    done_seen = 1'b0;
    repeat (80) begin
      @(negedge CLK);
      done_seen |= DONE;
    end
    W_VLD = 1'b0;
    chk("mid_no_done", done_seen, 0);
    run_block(1'b1, 1'b0, -1, lat);
    chk("abc2_digest", DIGEST, ABC);

    @(negedge CLK); INIT = 1'b1;
    @(negedge CLK); INIT = 1'b0;
    chk("init_iv", DIGEST, IV256);

    msg = '{default: 32'h0}; msg[0] = 32'h80000000;
    run_block(1'b1, 1'b1, -1, lat);
    chk("empty_latency", lat, 65 + 63);
    chk("empty_digest", DIGEST, EMPTY);

    msg = '{default: 32'h0}; msg[0] = 32'h61626380; msg[15] = 32'h18;
    run_block(1'b1, 1'b0, 10, lat);
    chk("glitch_latency", lat, 65);
    chk("glitch_digest", DIGEST, ABC);

    msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
            32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    run_block(1'b1, 1'b0, -1, lat);
    chk("two_b1_latency", lat, 65);
    msg = '{default: 32'h0}; msg[15] = 32'h1c0;
    run_block(1'b0, 1'b0, -1, lat);
    chk("two_b2_latency", lat, 65);
    chk("two_digest", DIGEST, TWO);

`ifdef SHA224_MODE_EN
    SEL224 = 1'b1;
    msg = '{default: 32'h0}; msg[0] = 32'h61626380; msg[15] = 32'h18;
    run_block(1'b1, 1'b0, -1, lat);
    chk("s224_digest_hi", DIGEST[255:32],
        224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7);
    chk("s224_digest_lo", DIGEST[31:0], 0);
    SEL224 = 1'b0;
    @(negedge CLK); INIT = 1'b1;
    @(negedge CLK); INIT = 1'b0;
    chk("s224_back_iv", DIGEST, IV256);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
